leds_pwm: RTL and testbench
===========================

// Module: leds_pwm
// PURPOSE
//  Memory-mapped LED peripheral for the HRM CPU I/O bus, generalising the plain 8-bit LED latch.
//  Each of NCH channels has a direct on/off bit, an optional blink enable and an 8-bit PWM brightness.
//  Sits on the CPU OUTBOX/INBOX I/O bus beside the other peripherals and drives the board LED pins.
// PARAMETERS
//  BASE_ADDR  8'h0A  first I/O address; block owns BASE_ADDR .. BASE_ADDR+2+NCH
//  NCH        8      channel count, 1..8
//  PRESCALE   12000  clk cycles per blink tick (1 ms at 12 MHz); must be >= 1
// PORTS
//  clk       in   1    clock
//  rst       in   1    synchronous, active-high reset
//  addr      in   8    I/O address, full 8 bits, decoded internally
//  write_en  in   1    write strobe; acted on only when addr is inside the block's window
//  din       in   8    write data
//  dout      out  8    registered read data for addr
//  leds      out  NCH  registered LED pin drive, active-high
// BEHAVIOUR
//  Register map, offsets from BASE_ADDR, all R/W:
//   +0     DIRECT[NCH-1:0]  per-channel on/off
//   +1     BLINK[NCH-1:0]   per-channel blink enable
//   +2     BDIV[7:0]        blink half-period in ticks
//   +3+i   DUTY[i][7:0]     brightness of channel i
//   Bits >= NCH of DIRECT/BLINK: writes ignored, read 0.
//  Reset: DIRECT=0, BLINK=0, BDIV=0, DUTY[*]=8'hFF, all counters 0, phase=1, leds=0, dout=0.
//  Write: when write_en and addr is in the window, the register updates on that clk edge.
//   Out-of-window writes are ignored.
//  Read: on every clk, dout <= register at addr (one-cycle latency).
//   dout <= 0 for out-of-window addr.
//   A write and a read of the same address in the same cycle return the OLD value.
//  Tick: prescaler counts 0..PRESCALE-1 and asserts tick for one clk at wrap.
//  Blink: bcnt counts ticks.
//   On a tick with bcnt == BDIV-1: bcnt <= 0 and phase toggles.
//   BDIV == 0: phase is held at 1 and bcnt at 0.
//   A write to BDIV clears bcnt and sets phase=1; the write wins over a coincident tick.
//  PWM: 8-bit pwm_cnt increments every clk and wraps 255->0.
//   pwm_on[i] = (DUTY[i] == 8'hFF) | (pwm_cnt < DUTY[i]), so 0 = off and FF = fully on.
//  Output: leds[i] <= DIRECT[i] & (~BLINK[i] | phase) & pwm_on[i].
//   One clk after the inputs change, glitch-free.
//  Legacy compatibility: after reset, writing V to +0 gives leds == V[NCH-1:0] two clk edges later, steady.
//  Reset mid-operation: all state returns to reset values on the same edge; no partial blink or PWM period survives.
// STRUCTURE
//  Shared include io_map.vh: LED_OFS_DIRECT=0, LED_OFS_BLINK=1, LED_OFS_BDIV=2, LED_OFS_DUTY=3,
//   and the BASE_ADDR constant used by the I/O decoder.
//  One sub-module, led_tick_gen, holds the prescaler and the blink counter/phase.
//   Inputs: clk, rst, bdiv, bdiv_wr. Outputs: tick, phase.
//  PWM counter, register file, read mux and output gating live in the top module.
// TESTING
//  1 Reset, write 8'hA5 to 0x0A -> leds==8'hA5 from 2nd edge on, held for 600 clks; read 0x0A -> dout==8'hA5 next clk.
//  2 DIRECT=FF, DUTY[0]=0x40 -> leds[0] high exactly 64 of every 256 clks; DUTY[0]=0 -> never high; DUTY[0]=FF -> always high.
//  3 PRESCALE=4 in the bench, BDIV=3, BLINK=01, DIRECT=01 -> leds[0] toggles every 12 clks; BDIV=0 -> leds[0] stays 1.
//  4 Write BDIV in the same cycle as a tick -> bcnt==0 and phase==1 afterwards; no toggle on that edge.
//  5 Write to 0x09 and to BASE+3+NCH -> no register changes; read of either -> dout==0; same-cycle write+read of 0x0B returns old value.
//  6 Assert rst mid-blink with DUTY changed -> leds=0, dout=0 and DUTY=FF next edge; bit 7 write with NCH=4 reads back 0.

Source files
------------

// File: rtl/leds_pwm_pkg.sv
// leds_pwm_pkg
//  Shared constants and types for the LED peripheral on the HRM CPU I/O bus.
//  - LED_BASE_ADDR : default I/O address of the block (first register)
//  - LED_OFS_*     : register offsets from the base address
//  - io_req_t      : one I/O bus beat (address, write strobe, write data)
//  - pwm_on()      : per-channel PWM compare
package leds_pwm_pkg;

    localparam logic [7:0] LED_BASE_ADDR  = 8'h0A;

    localparam logic [7:0] LED_OFS_DIRECT = 8'd0;
    localparam logic [7:0] LED_OFS_BLINK  = 8'd1;
    localparam logic [7:0] LED_OFS_BDIV   = 8'd2;
    localparam logic [7:0] LED_OFS_DUTY   = 8'd3;

    typedef struct packed {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] data;
    } io_req_t;

    // FF is treated as fully on so a channel can reach 100% brightness;
    // otherwise the channel is on for the first 'duty' counts of 256.
    function automatic logic pwm_on(input logic [7:0] duty, input logic [7:0] cnt);
        return (duty == 8'hFF) | (cnt < duty);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
//  Millisecond-style prescaler plus blink half-period counter.
//  Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bdiv      : blink half-period in ticks (0 = blink disabled, phase held 1)
//   bdiv_wr   : bdiv is being written this cycle; restarts the blink period
//   tick      : one-clk pulse each time the prescaler wraps
//   phase     : blink phase, 1 = LED may light
module led_tick_gen #(
    parameter int PRESCALE = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bdiv,
    input  logic       bdiv_wr,
    output logic       tick,
    output logic       phase
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;
    logic [7:0]    bcnt;

    assign tick = (pcnt == PMAX);

    always_ff @(posedge clk) begin
        if (rst)       pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + PW'(1);
    end

    // A bdiv write restarts the period and takes priority over a tick on
    // the same edge, so software always sees a full first half-period.
    always_ff @(posedge clk) begin
        if (rst || bdiv_wr || bdiv == 8'd0) begin
            bcnt  <= 8'd0;
            phase <= 1'b1;
        end else if (tick) begin
            if (bcnt == bdiv - 8'd1) begin
                bcnt  <= 8'd0;
                phase <= ~phase;
            end else begin
                bcnt  <= bcnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/leds_pwm.sv
// leds_pwm
//  Memory-mapped LED peripheral: per-channel on/off, blink enable and 8-bit
//  PWM brightness. Registers at BASE_ADDR: +0 DIRECT, +1 BLINK, +2 BDIV,
//  +3+i DUTY[i]. Reads are registered (one-cycle latency, old value on a
//  same-cycle write); out-of-window addresses read 0 and ignore writes.
//  Ports:
//   clk, rst  : clock, synchronous active-high reset
//   addr      : 8-bit I/O address
//   write_en  : write strobe
//   din       : write data
//   dout      : registered read data
//   leds      : registered LED drive, active-high
module leds_pwm
    import leds_pwm_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = LED_BASE_ADDR,
    parameter int         NCH       = 8,
    parameter int         PRESCALE  = 12000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     addr,
    input  logic           write_en,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic [NCH-1:0] leds
);

    io_req_t req;
    assign req = '{addr: addr, wr: write_en, data: din};

    // Offset wraps for addresses below the base, so one compare covers both ends.
    logic [7:0] ofs;
    logic       in_win, wr;
    assign ofs    = req.addr - BASE_ADDR;
    assign in_win = (ofs < 8'(NCH + 3));
    assign wr     = req.wr & in_win;

    logic [NCH-1:0]       direct, blink;
    logic [7:0]           bdiv;
    logic [NCH-1:0][7:0]  duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            direct <= '0;
            blink  <= '0;
            bdiv   <= 8'd0;
            duty   <= {NCH{8'hFF}};
        end else if (wr) begin
            if (ofs == LED_OFS_DIRECT) direct <= req.data[NCH-1:0];
            if (ofs == LED_OFS_BLINK)  blink  <= req.data[NCH-1:0];
            if (ofs == LED_OFS_BDIV)   bdiv   <= req.data;
            for (int i = 0; i < NCH; i++)
                if (ofs == LED_OFS_DUTY + 8'(i)) duty[i] <= req.data;
        end
    end

    logic [7:0] rdata;
    always_comb begin
        rdata = 8'd0;
        if (in_win) begin
            case (ofs)
                LED_OFS_DIRECT: rdata[NCH-1:0] = direct;
                LED_OFS_BLINK:  rdata[NCH-1:0] = blink;
                LED_OFS_BDIV:   rdata          = bdiv;
                default: begin
                    for (int i = 0; i < NCH; i++)
                        if (ofs == LED_OFS_DUTY + 8'(i)) rdata = duty[i];
                end
            endcase
        end
    end

    logic phase, unused_tick;
    led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .bdiv    (bdiv),
        .bdiv_wr (wr && ofs == LED_OFS_BDIV),
        .tick    (unused_tick),
        .phase   (phase)
    );

    logic [7:0] pwm_cnt;
    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= 8'd0;
        else     pwm_cnt <= pwm_cnt + 8'd1;
    end

    logic [NCH-1:0] on;
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign on[g] = pwm_on(duty[g], pwm_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'd0;
            leds <= '0;
        end else begin
            dout <= rdata;
            leds <= direct & (~blink | {NCH{phase}}) & on;
        end
    end

endmodule

// File: tb/tb_leds_pwm.sv
module tb_leds_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr = 8'h00;
    logic       write_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout, dout4;
    logic [7:0] leds;
    logic [3:0] leds4;

    always #5 clk = ~clk;

    leds_pwm #(.BASE_ADDR(8'h0A), .NCH(8), .PRESCALE(4)) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .write_en(write_en),
        .din(din), .dout(dout), .leds(leds)
    );

    leds_pwm #(.BASE_ADDR(8'h0A), .NCH(4), .PRESCALE(4)) u_dut4 (
        .clk(clk), .rst(rst), .addr(addr), .write_en(write_en),
        .din(din), .dout(dout4), .leds(leds4)
    );

    // edges since reset; with PRESCALE=4 the prescaler value equals ecnt % 4
    int ecnt = 0;
    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // apply one cycle of bus inputs; returns #1 after the edge that consumed them
    task automatic drive(input logic [7:0] a, input logic w, input logic [7:0] d);
        addr = a; write_en = w; din = d;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(8'h00, 1'b0, 8'h00);
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] e;
        sb_q.push_back(exp);
        drive(a, 1'b0, 8'h00);
        e = sb_q.pop_front();
        chk(nm, dout, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(); idle();
        chk("rst_leds", leds, 8'h00);
        chk("rst_dout", dout, 8'h00);
        chk("rst_leds4", leds4, 4'h0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic       w;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[17];

    initial begin
        // each vector is one cycle; exp is dout after that edge (pre-write value)
        vt[0]  = '{8'h0A, 1'b0, 8'h00, 8'h00};
        vt[1]  = '{8'h0D, 1'b0, 8'h00, 8'hFF};
        vt[2]  = '{8'h0A, 1'b1, 8'hA5, 8'h00};
        vt[3]  = '{8'h0A, 1'b0, 8'h00, 8'hA5};
        vt[4]  = '{8'h0B, 1'b1, 8'h3C, 8'h00};
        vt[5]  = '{8'h0B, 1'b0, 8'h00, 8'h3C};
        vt[6]  = '{8'h0C, 1'b1, 8'h07, 8'h00};
        vt[7]  = '{8'h0C, 1'b0, 8'h00, 8'h07};
        vt[8]  = '{8'h14, 1'b1, 8'h55, 8'hFF};
        vt[9]  = '{8'h14, 1'b0, 8'h00, 8'h55};
        vt[10] = '{8'h09, 1'b1, 8'h77, 8'h00};
        vt[11] = '{8'h09, 1'b0, 8'h00, 8'h00};
        vt[12] = '{8'h15, 1'b1, 8'h66, 8'h00};
        vt[13] = '{8'h15, 1'b0, 8'h00, 8'h00};
        vt[14] = '{8'h0A, 1'b0, 8'h00, 8'hA5};
        vt[15] = '{8'h0D, 1'b0, 8'h00, 8'hFF};
        vt[16] = '{8'h14, 1'b0, 8'h00, 8'h55};

        // register map, window edges, same-cycle write+read
        do_reset();
        for (int i = 0; i < 17; i++) begin
            logic [7:0] e;
            sb_q.push_back(vt[i].exp);
            drive(vt[i].a, vt[i].w, vt[i].d);
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_dout", i), dout, e);
        end

        // legacy latch behaviour
        do_reset();
        drive(8'h0A, 1'b1, 8'hA5);
        chk("legacy_edge1", leds, 8'h00);
        for (int k = 0; k < 600; k++) begin
            idle();
            chk("legacy_hold", leds, 8'hA5);
        end
        rd("legacy_read", 8'h0A, 8'hA5);

        // PWM duty
        do_reset();
        drive(8'h0A, 1'b1, 8'hFF);
        begin
            logic [7:0] duties[3];
            int         exps[3];
            duties[0] = 8'h40; exps[0] = 64;
            duties[1] = 8'h00; exps[1] = 0;
            duties[2] = 8'hFF; exps[2] = 256;
            for (int j = 0; j < 3; j++) begin
                int n;
                n = 0;
                drive(8'h0D, 1'b1, duties[j]);
                idle(); idle();
                for (int k = 0; k < 256; k++) begin
                    idle();
                    if (leds[0] === 1'b1) n++;
                end
                chk($sformatf("pwm_duty_%0h", duties[j]), n, exps[j]);
                chk("pwm_others_on", leds[7:1], 7'h7F);
            end
        end

        // blink period: 3 ticks * 4 clks = 12 clks per half-period
        do_reset();
        drive(8'h0A, 1'b1, 8'h01);
        drive(8'h0B, 1'b1, 8'h01);
        drive(8'h0C, 1'b1, 8'h03);
        begin
            int   last, ntog;
            logic prev;
            last = -1; ntog = 0; prev = leds[0];
            for (int k = 1; k <= 80; k++) begin
                idle();
                if (leds[0] !== prev) begin
                    if (last >= 0) chk("blink_period", k - last, 12);
                    last = k; ntog++; prev = leds[0];
                end
            end
            chk("blink_toggle_count_ok", ntog >= 5, 1);
        end
        drive(8'h0C, 1'b1, 8'h00);
        idle();
        for (int k = 0; k < 50; k++) begin
            idle();
            chk("bdiv0_steady", leds[0], 1'b1);
        end

        // BDIV write coinciding with a tick
        do_reset();
        drive(8'h0A, 1'b1, 8'h01);
        drive(8'h0B, 1'b1, 8'h01);
        drive(8'h0C, 1'b1, 8'h02);
        begin
            int n;
            n = 0;
            while (leds[0] !== 1'b0 && n < 40) begin
                idle(); n++;
            end
            chk("tick_wr_phase_low_seen", n < 40, 1);
            n = 0;
            while (ecnt % 4 != 3 && n < 8) begin
                idle(); n++;
            end
            chk("tick_wr_aligned", ecnt % 4, 3);
            drive(8'h0C, 1'b1, 8'h02);
            for (int k = 1; k <= 9; k++) begin
                idle();
                chk($sformatf("tick_wr_k%0d", k), leds[0], (k <= 8) ? 1'b1 : 1'b0);
            end
        end

        // reset mid-blink with modified duty; narrow channel count
        do_reset();
        drive(8'h0A, 1'b1, 8'hFF);
        drive(8'h0B, 1'b1, 8'h01);
        drive(8'h0C, 1'b1, 8'h03);
        drive(8'h0D, 1'b1, 8'h40);
        for (int k = 0; k < 20; k++) idle();
        rst = 1'b1;
        drive(8'h0D, 1'b0, 8'h00);
        chk("midrst_leds", leds, 8'h00);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_leds4", leds4, 4'h0);
        chk("midrst_dout4", dout4, 8'h00);
        rst = 1'b0;
        rd("midrst_duty0", 8'h0D, 8'hFF);
        rd("midrst_direct", 8'h0A, 8'h00);
        drive(8'h0A, 1'b1, 8'h8F);
        rd("wide_direct", 8'h0A, 8'h8F);
        chk("nch4_direct_read", dout4, 8'h0F);
        idle();
        chk("wide_leds", leds, 8'h8F);
        chk("nch4_leds", leds4, 4'hF);
        drive(8'h0B, 1'b1, 8'hF0);
        rd("nch4_blink_wide", 8'h0B, 8'hF0);
        chk("nch4_blink_read", dout4, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
